lpgbt_uplink_capture: RTL and testbench
=======================================

# lpgbt_uplink_capture

Parametrised multi-channel capture buffer for the lpGBT uplink, sitting in the clk40 domain between the lpGBT-FPGA uplink core and the AXI register block. It extracts N_CH e-link fields from each 234-bit uplink user-data frame and writes them into per-channel ring buffers. A trigger state machine (immediate, pattern-match or external trigger) freezes the buffers with programmable pre- and post-trigger depth. Frames are then read out one word per strobe through a register-style interface.

## Interface
- N_CH, 4, number of captured e-link channels (1..16).
- ELINK_W, 32, bits captured per channel per frame (1..32).
- DEPTH, 256, frames per channel buffer; power of two, 16..4096.
- AW, $clog2(DEPTH), derived buffer address width; not overridden.
- clk40_i  in  1  uplink frame clock; the only clock.
- uplinkRst_i  in  1  synchronous, active-high reset.
- uplinkUserData_i  in  234  uplink user-data frame.
- uplinkrdy_i  in  1  frame valid / uplink locked.
- uplinkFEC_i  in  1  FEC correction flag for the current frame.
- ch_offset_i  in  N_CH*8  per-channel LSB bit offset into uplinkUserData_i.
- arm_i  in  1  single-cycle pulse: clear and start capture.
- trig_mode_i  in  2  0 immediate, 1 pattern, 2 external, 3 reserved (behaves as 0).
- trig_ch_i  in  4  channel compared in pattern mode.
- trig_pattern_i  in  ELINK_W  value compared in pattern mode.
- trig_mask_i  in  ELINK_W  compare mask; a 1 means the bit is compared.
- ext_trig_i  in  1  external trigger level, sampled each cycle.
- post_trig_i  in  AW  frames written after the trigger frame.
- rd_ch_i  in  4  readout channel select.
- rd_strobe_i  in  1  advance the readout pointer.
- rd_data_o  out  ELINK_W  readout word.
- state_o  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- fill_o  out  AW+1  valid frames in the buffer, saturating at DEPTH.
- drop_o  out  1  sticky: uplinkrdy_i went low while in ARMED or POST.
- fec_cnt_o  out  16  FEC-flagged frame count (see Configuration).

## Operation
- Channel extraction: field c = uplinkUserData_i[off +: ELINK_W], with off = ch_offset_i[8c +: 8]. If off > 234-ELINK_W, off is clamped to 234-ELINK_W.
- A frame is valid when uplinkrdy_i=1. Only valid frames are written, counted or compared.
- IDLE: no writes. arm_i moves to ARMED and clears wr_ptr, fill, drop and post count.
- ARMED: every valid frame writes all channels at wr_ptr; wr_ptr increments modulo DEPTH; fill saturates at DEPTH.
- Trigger is evaluated on the same valid frame that is written. Mode 0: the first valid frame. Mode 1: (field[trig_ch_i] ^ trig_pattern_i) & trig_mask_i == 0. Mode 2: ext_trig_i=1. If trig_ch_i >= N_CH, mode 1 never triggers.
- The trigger frame moves the machine to POST, or directly to DONE if post_trig_i=0.
- POST: each valid frame is written and post count increments. When post count reaches post_trig_i, that write completes and the state moves to DONE. post_trig_i is sampled at the trigger; values >= DEPTH are clamped to DEPTH-1.
- DONE: writes stop. rd_ptr loads (wr_ptr - fill) mod DEPTH, which is the oldest frame.
- Readout in DONE: each rd_strobe_i increments rd_ptr modulo DEPTH. rd_strobe_i is ignored in any other state.
- arm_i in any state restarts: go to ARMED and clear as above. This has priority over a simultaneous trigger or strobe.
- drop_o: set when uplinkrdy_i=0 in ARMED or POST. Cleared only by arm_i or reset.
- Reset mid-operation: state IDLE, all pointers and counters 0, drop_o 0. Buffer contents are not cleared.

## Timing
- Reset values: state_o 0, fill_o 0, drop_o 0, fec_cnt_o 0, rd_data_o 0.
- Buffers are inferred simple dual-port block RAM, one per channel.
- rd_data_o is registered as mem[rd_ch_i][rd_ptr]. It is valid 1 cycle after any change of rd_ptr or rd_ch_i.
- A strobe at cycle t presents the next word at t+2.
- state_o, fill_o and drop_o update 1 cycle after the causing frame or pulse.
- The first readable word in DONE appears 2 cycles after state_o becomes 3.
- Throughput: one frame per clk40 cycle, no back-pressure.

## Configuration
- LPGBT_CAPTURE_FEC_COUNT_EN defined: fec_cnt_o counts valid frames with uplinkFEC_i=1 in ARMED and POST. The counter saturates at 0xFFFF and is cleared by arm_i.
- Not defined: the counter logic is absent, fec_cnt_o is constant 0, and uplinkFEC_i is unused.

## Structure
- Package lpgbt_capture_pkg holds:
  - the capture_state_t enum (IDLE, ARMED, POST, DONE);
  - the trigger-mode localparams;
  - the constant LPGBT_UPLINK_W = 234.
- Sub-module lpgbt_capture_ram: one-channel simple dual-port RAM (DEPTH x ELINK_W) with registered read. It is instantiated N_CH times in a generate loop.

## Test plan
- Immediate mode with DEPTH=16, post_trig_i=3 and a counting frame pattern (field0 = frame index): pulse arm_i at frame 0 -> DONE after frame 3, fill_o=4, and readout returns 0,1,2,3.
- Pattern mode with trig_pattern_i=0xA5, mask 0xFF, trig_ch_i=2, post_trig_i=4, DEPTH=16, and 0xA5 on ch2 at frame 40 -> readout starts at frame 29 and ends at frame 44 (16 words), with the trigger word at index 11.
- post_trig_i=20 with DEPTH=16 -> clamped to 15, and the trigger frame is the first word read.
- uplinkrdy_i low for 3 cycles in ARMED -> drop_o=1, 3 frames not written, fill_o short by 3. A later arm_i clears drop_o.
- arm_i in the same cycle as ext_trig_i=1 in POST -> state ARMED, fill_o=0.
- With LPGBT_CAPTURE_FEC_COUNT_EN defined, 70000 FEC-flagged frames -> fec_cnt_o=0xFFFF. Without the macro -> fec_cnt_o=0.

Source files
------------

// File: rtl/lpgbt_capture_pkg.sv
// Shared types and constants for the lpGBT uplink capture buffer.
// No logic, no latency, no backpressure.
package lpgbt_capture_pkg;

    localparam int LPGBT_UPLINK_W = 234;

    localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
    localparam logic [1:0] TRIG_PATTERN   = 2'd1;
    localparam logic [1:0] TRIG_EXTERNAL  = 2'd2;
    localparam logic [1:0] TRIG_RESERVED  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } capture_state_t;

endpackage

// File: rtl/lpgbt_capture_ram.sv
// One-channel simple dual-port capture RAM (DEPTH x ELINK_W), registered read.
// Read latency 1 cycle; no backpressure, one write and one read per cycle.
module lpgbt_capture_ram #(
    parameter int DEPTH   = 256,
    parameter int ELINK_W = 32,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk40_i,
    input  logic               rst,
    input  logic               wr_vld,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ELINK_W-1:0] wr_dat,
    input  logic [AW-1:0]      rd_addr,
    output logic [ELINK_W-1:0] rd_dat
);

    logic [ELINK_W-1:0] mem [DEPTH];

    always_ff @(posedge clk40_i) begin
        if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Output register reset only; array contents survive reset.
    always_ff @(posedge clk40_i) begin
        if (rst) begin
            rd_dat <= '0;
        end else begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/lpgbt_uplink_capture.sv
// Multi-channel lpGBT uplink capture with pre/post trigger; FEC counter under LPGBT_CAPTURE_FEC_COUNT_EN.
// Status 1 cycle after the frame; readout word 2 cycles after strobe; no backpressure, one frame per clk40.
module lpgbt_uplink_capture
    import lpgbt_capture_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int ELINK_W = 32,
    parameter int DEPTH   = 256,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic                      clk40_i,
    input  logic                      uplinkRst_i,
    input  logic [LPGBT_UPLINK_W-1:0] uplinkUserData_i,
    input  logic                      uplinkrdy_i,
    input  logic                      uplinkFEC_i,
    input  logic [N_CH*8-1:0]         ch_offset_i,
    input  logic                      arm_i,
    input  logic [1:0]                trig_mode_i,
    input  logic [3:0]                trig_ch_i,
    input  logic [ELINK_W-1:0]        trig_pattern_i,
    input  logic [ELINK_W-1:0]        trig_mask_i,
    input  logic                      ext_trig_i,
    input  logic [AW-1:0]             post_trig_i,
    input  logic [3:0]                rd_ch_i,
    input  logic                      rd_strobe_i,
    output logic [ELINK_W-1:0]        rd_data_o,
    output logic [1:0]                state_o,
    output logic [AW:0]               fill_o,
    output logic                      drop_o,
    output logic [15:0]               fec_cnt_o
);

    localparam int MAX_OFF = LPGBT_UPLINK_W - ELINK_W;

    capture_state_t state_q, state_d;

    logic [ELINK_W-1:0] field   [N_CH];
    logic [ELINK_W-1:0] rd_word [N_CH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q, post_cnt_q, post_lim_q;
    logic [AW:0]   fill_q;
    logic          drop_q, rd_loaded_q;
    logic [3:0]    rd_ch_q;

    logic               capturing, wr_en, trig_hit, trig_fire, post_last;
    logic               pat_vld, pat_hit;
    logic [ELINK_W-1:0] pat_sel;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [7:0] off_raw, off;
        assign off_raw  = ch_offset_i[8*c +: 8];
        assign off      = (off_raw > 8'(MAX_OFF)) ? 8'(MAX_OFF) : off_raw;
        assign field[c] = ELINK_W'(uplinkUserData_i >> off);

        lpgbt_capture_ram #(
            .DEPTH   (DEPTH),
            .ELINK_W (ELINK_W),
            .AW      (AW)
        ) u_ram (
            .clk40_i (clk40_i),
            .rst     (uplinkRst_i),
            .wr_vld  (wr_en),
            .wr_addr (wr_ptr_q),
            .wr_dat  (field[c]),
            .rd_addr (rd_ptr_q),
            .rd_dat  (rd_word[c])
        );
    end

    // A channel select beyond N_CH leaves pat_vld low, so pattern mode never fires.
    always_comb begin
        pat_vld = 1'b0;
        pat_sel = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (trig_ch_i == 4'(c)) begin
                pat_vld = 1'b1;
                pat_sel = field[c];
            end
        end
        pat_hit = pat_vld && (((pat_sel ^ trig_pattern_i) & trig_mask_i) == '0);
        case (trig_mode_i)
            TRIG_PATTERN:  trig_hit = pat_hit;
            TRIG_EXTERNAL: trig_hit = ext_trig_i;
            default:       trig_hit = 1'b1;
        endcase
    end

    // arm_i suppresses the write of its own cycle so a restart begins clean.
    assign capturing = (state_q == ARMED) || (state_q == POST);
    assign wr_en     = !arm_i && uplinkrdy_i && capturing;
    assign trig_fire = wr_en && (state_q == ARMED) && trig_hit;
    assign post_last = wr_en && (state_q == POST) && ((post_cnt_q + AW'(1)) == post_lim_q);

    always_ff @(posedge clk40_i) begin
        if (uplinkRst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (arm_i) begin
            state_d = ARMED;
        end else begin
            case (state_q)
                ARMED:   if (trig_fire) state_d = (post_trig_i == '0) ? DONE : POST;
                POST:    if (post_last) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        state_o   = state_q;
        fill_o    = fill_q;
        drop_o    = drop_q;
        rd_data_o = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (rd_ch_q == 4'(c)) rd_data_o = rd_word[c];
        end
    end

    // post_trig_i is AW bits wide, so the post depth can never exceed DEPTH-1.
    always_ff @(posedge clk40_i) begin
        if (uplinkRst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            post_cnt_q  <= '0;
            post_lim_q  <= '0;
            fill_q      <= '0;
            drop_q      <= 1'b0;
            rd_loaded_q <= 1'b0;
            rd_ch_q     <= '0;
        end else begin
            rd_ch_q <= rd_ch_i;
            if (arm_i) begin
                wr_ptr_q    <= '0;
                post_cnt_q  <= '0;
                fill_q      <= '0;
                drop_q      <= 1'b0;
                rd_loaded_q <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                    if (fill_q != (AW+1)'(DEPTH)) fill_q <= fill_q + (AW+1)'(1);
                end
                if (capturing && !uplinkrdy_i) drop_q <= 1'b1;
                if (trig_fire) begin
                    post_lim_q <= post_trig_i;
                    post_cnt_q <= '0;
                end else if (wr_en && (state_q == POST)) begin
                    post_cnt_q <= post_cnt_q + AW'(1);
                end
                // Oldest frame is loaded on the first DONE cycle; strobes count after that.
                if (state_q == DONE) begin
                    if (!rd_loaded_q) begin
                        rd_ptr_q    <= wr_ptr_q - fill_q[AW-1:0];
                        rd_loaded_q <= 1'b1;
                    end else if (rd_strobe_i) begin
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                    end
                end
            end
        end
    end

`ifdef LPGBT_CAPTURE_FEC_COUNT_EN
    logic [15:0] fec_cnt_q;

    always_ff @(posedge clk40_i) begin
        if (uplinkRst_i || arm_i) begin
            fec_cnt_q <= '0;
        end else if (wr_en && uplinkFEC_i && (fec_cnt_q != 16'hFFFF)) begin
            fec_cnt_q <= fec_cnt_q + 16'd1;
        end
    end

    assign fec_cnt_o = fec_cnt_q;
`else
    logic unused_fec;
    assign unused_fec = uplinkFEC_i;
    assign fec_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_lpgbt_uplink_capture.sv
// Directed bench for lpgbt_uplink_capture (N_CH=4, ELINK_W=32, DEPTH=16).
module tb_lpgbt_uplink_capture;

    localparam int N_CH    = 4;
    localparam int ELINK_W = 32;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;

    logic                clk40_i = 1'b0;
    logic                uplinkRst_i;
    logic [233:0]        uplinkUserData_i;
    logic                uplinkrdy_i;
    logic                uplinkFEC_i;
    logic [N_CH*8-1:0]   ch_offset_i;
    logic                arm_i;
    logic [1:0]          trig_mode_i;
    logic [3:0]          trig_ch_i;
    logic [ELINK_W-1:0]  trig_pattern_i;
    logic [ELINK_W-1:0]  trig_mask_i;
    logic                ext_trig_i;
    logic [AW-1:0]       post_trig_i;
    logic [3:0]          rd_ch_i;
    logic                rd_strobe_i;
    logic [ELINK_W-1:0]  rd_data_o;
    logic [1:0]          state_o;
    logic [AW:0]         fill_o;
    logic                drop_o;
    logic [15:0]         fec_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk40_i = ~clk40_i;

    lpgbt_uplink_capture #(
        .N_CH    (N_CH),
        .ELINK_W (ELINK_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk40_i          (clk40_i),
        .uplinkRst_i      (uplinkRst_i),
        .uplinkUserData_i (uplinkUserData_i),
        .uplinkrdy_i      (uplinkrdy_i),
        .uplinkFEC_i      (uplinkFEC_i),
        .ch_offset_i      (ch_offset_i),
        .arm_i            (arm_i),
        .trig_mode_i      (trig_mode_i),
        .trig_ch_i        (trig_ch_i),
        .trig_pattern_i   (trig_pattern_i),
        .trig_mask_i      (trig_mask_i),
        .ext_trig_i       (ext_trig_i),
        .post_trig_i      (post_trig_i),
        .rd_ch_i          (rd_ch_i),
        .rd_strobe_i      (rd_strobe_i),
        .rd_data_o        (rd_data_o),
        .state_o          (state_o),
        .fill_o           (fill_o),
        .drop_o           (drop_o),
        .fec_cnt_o        (fec_cnt_o)
    );

    typedef struct {
        logic [1:0] mode;
        logic [3:0] tch;
        logic [3:0] post;
        int         trig_frame;
        int         n_frames;
        logic [4:0] exp_fill;
        int         exp_first;
        int         exp_count;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk40_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ch0 = index, ch1 = index^FFFF0000, ch2 = {index, 0xA5 or 0x00}, ch3 (clamped offset) = C0DE0000|index.
    function automatic logic [233:0] mk_frame(input int idx, input bit pat);
        logic [233:0] d;
        logic [31:0]  v;
        v           = 32'(idx);
        d           = '0;
        d[31:0]     = v;
        d[63:32]    = v ^ 32'hFFFF_0000;
        d[95:64]    = {v[23:0], pat ? 8'hA5 : 8'h00};
        d[233:202]  = 32'hC0DE_0000 | v;
        return d;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        uplinkRst_i      = 1'b1;
        uplinkUserData_i = '0;
        uplinkrdy_i      = 1'b0;
        uplinkFEC_i      = 1'b0;
        ch_offset_i      = {8'd250, 8'd64, 8'd32, 8'd0};
        arm_i            = 1'b0;
        trig_mode_i      = 2'd0;
        trig_ch_i        = 4'd0;
        trig_pattern_i   = 32'h0000_00A5;
        trig_mask_i      = 32'h0000_00FF;
        ext_trig_i       = 1'b0;
        post_trig_i      = '0;
        rd_ch_i          = 4'd0;
        rd_strobe_i      = 1'b0;

        // mode, trig_ch, post, trig frame, frames sent, fill, first word, words read
        vecs[0] = '{2'd0, 4'd0, 4'd3,  0,  4, 5'd4,  0,  4};
        vecs[1] = '{2'd1, 4'd2, 4'd4, 40, 45, 5'd16, 29, 16};
        vecs[2] = '{2'd2, 4'd0, 4'd15, 5, 21, 5'd16, 5, 16};
        vecs[3] = '{2'd3, 4'd0, 4'd0,  0,  1, 5'd1,  0,  1};
        vecs[4] = '{2'd2, 4'd0, 4'd2,  7, 10, 5'd10, 0, 10};

        repeat (3) tick();
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_fill", 32'(fill_o), 32'd0);
        chk("reset_drop", 32'(drop_o), 32'd0);
        chk("reset_fec", 32'(fec_cnt_o), 32'd0);
        chk("reset_rd_data", rd_data_o, 32'd0);
        uplinkRst_i = 1'b0;
        tick();
        chk("idle_after_reset", 32'(state_o), 32'd0);

        for (int v = 0; v < 5; v++) begin
            trig_mode_i = vecs[v].mode;
            trig_ch_i   = vecs[v].tch;
            post_trig_i = vecs[v].post;
            arm_i = 1'b1;
            tick();
            arm_i = 1'b0;
            for (int f = 0; f < vecs[v].n_frames; f++) begin
                uplinkrdy_i      = 1'b1;
                uplinkUserData_i = mk_frame(f, (vecs[v].mode == 2'd1) && (f == vecs[v].trig_frame));
                ext_trig_i       = (vecs[v].mode == 2'd2) && (f == vecs[v].trig_frame);
                tick();
            end
            uplinkrdy_i = 1'b0;
            ext_trig_i  = 1'b0;
            chk($sformatf("v%0d_state", v), 32'(state_o), 32'd3);
            chk($sformatf("v%0d_fill", v), 32'(fill_o), 32'(vecs[v].exp_fill));
            tick();
            tick();
            for (int w = 0; w < vecs[v].exp_count; w++) begin
                if (w > 0) begin
                    rd_strobe_i = 1'b1;
                    tick();
                    rd_strobe_i = 1'b0;
                    tick();
                end
                chk($sformatf("v%0d_word%0d", v, w), rd_data_o, 32'(vecs[v].exp_first + w));
            end
            rd_ch_i = 4'd3;
            tick();
            chk($sformatf("v%0d_ch3_clamped", v), rd_data_o,
                32'hC0DE_0000 | 32'(vecs[v].exp_first + vecs[v].exp_count - 1));
            rd_ch_i = 4'd0;
            tick();
        end

        // Three invalid frames in ARMED: drop set, fill short by three.
        trig_mode_i = 2'd1;
        trig_ch_i   = 4'd15;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        for (int f = 0; f < 10; f++) begin
            uplinkrdy_i      = !(f >= 5 && f < 8);
            uplinkUserData_i = mk_frame(f, 1'b1);
            tick();
        end
        uplinkrdy_i = 1'b0;
        chk("drop_set", 32'(drop_o), 32'd1);
        chk("drop_fill", 32'(fill_o), 32'd7);
        chk("drop_state_armed", 32'(state_o), 32'd1);
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        chk("drop_cleared_by_arm", 32'(drop_o), 32'd0);
        chk("drop_rearm_fill", 32'(fill_o), 32'd0);

        // arm_i together with ext_trig_i while in POST restarts capture.
        trig_mode_i = 2'd2;
        post_trig_i = 4'd10;
        uplinkrdy_i = 1'b1;
        ext_trig_i  = 1'b1;
        uplinkUserData_i = mk_frame(0, 1'b0);
        tick();
        ext_trig_i = 1'b0;
        chk("post_entered", 32'(state_o), 32'd2);
        tick();
        tick();
        chk("post_fill", 32'(fill_o), 32'd3);
        arm_i      = 1'b1;
        ext_trig_i = 1'b1;
        tick();
        arm_i       = 1'b0;
        ext_trig_i  = 1'b0;
        uplinkrdy_i = 1'b0;
        chk("arm_over_trig_state", 32'(state_o), 32'd1);
        chk("arm_over_trig_fill", 32'(fill_o), 32'd0);

        // FEC count with a channel select that can never match.
        trig_mode_i = 2'd1;
        trig_ch_i   = 4'd15;
        uplinkFEC_i = 1'b1;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
`ifdef LPGBT_CAPTURE_FEC_COUNT_EN
        for (int f = 0; f < 70000; f++) begin
            uplinkrdy_i      = 1'b1;
            uplinkUserData_i = mk_frame(f, 1'b1);
            tick();
        end
        chk("fec_saturated", 32'(fec_cnt_o), 32'h0000_FFFF);
`else
        for (int f = 0; f < 100; f++) begin
            uplinkrdy_i      = 1'b1;
            uplinkUserData_i = mk_frame(f, 1'b1);
            tick();
        end
        chk("fec_disabled", 32'(fec_cnt_o), 32'd0);
`endif
        uplinkFEC_i = 1'b0;
        chk("bad_trig_ch_stays_armed", 32'(state_o), 32'd1);
        chk("fill_saturates", 32'(fill_o), 32'd16);
        uplinkrdy_i = 1'b0;
        tick();
        chk("drop_before_reset", 32'(drop_o), 32'd1);

        // Reset in the middle of a capture.
        uplinkRst_i = 1'b1;
        tick();
        uplinkRst_i = 1'b0;
        chk("midreset_state", 32'(state_o), 32'd0);
        chk("midreset_fill", 32'(fill_o), 32'd0);
        chk("midreset_drop", 32'(drop_o), 32'd0);
        chk("midreset_fec", 32'(fec_cnt_o), 32'd0);
        uplinkrdy_i = 1'b1;
        tick();
        chk("idle_ignores_frames", 32'(fill_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
